// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: requester/consumer handshake bundle around the shared ALU scheduler
interface alu_rr_scheduler_if #(
    parameter int W    = 6,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*2-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU among NREQ requesters
module alu_rr_scheduler #(
    parameter int W    = 6,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_rr_scheduler_if.slave   bus,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [1:0]          alu_op,
    input  logic [W-1:0]        alu_out,
    input  logic                alu_cout,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state, next;
    logic [IDW-1:0] rr_ptr, winner, rsp_id;
    logic           found, accept, rsp_valid, rsp_cout;
    logic [W-1:0]   rsp_data;

    // Scan from the highest offset down so the last hit is the first in rr order.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[IDW'((int'(rr_ptr) + k) % NREQ)]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = (state == IDLE)  ? (found ? ISSUE : IDLE) :
               (state == ISSUE) ? RESP :
               (bus.rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        accept        = (state == IDLE) && found;
        busy          = state != IDLE;
        bus.req_ready = accept ? (NREQ'(1) << winner) : '0;
    end

    // Operands stay registered outside ISSUE so the ALU inputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                alu_a  <= bus.req_a[winner*W +: W];
                alu_b  <= bus.req_b[winner*W +: W];
                alu_op <= bus.req_op[winner*2 +: 2];
                rsp_id <= winner;
                rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            end
            if (state == ISSUE) begin
                rsp_data  <= alu_out;
                rsp_cout  <= alu_cout;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready) rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_cout  = rsp_cout;
    assign bus.rsp_id    = rsp_id;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed and randomized checks of the scheduler against a transaction-level model
module tb_alu_rr_scheduler;
    localparam int W    = 6;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [1:0]   alu_op;
    logic         alu_cout, busy;

    alu_rr_scheduler_if #(.W(W), .NREQ(NREQ)) bif ();

    alu_rr_scheduler #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cout(alu_cout), .busy(busy)
    );

    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_cout, alu_out} = alu_ref(alu_a, alu_b, alu_op);

    logic [NREQ*W-1:0] ta, tbv;
    logic [NREQ*2-1:0] top;
    int vectors = 0;
    int miscompares = 0;

    // Model: one outstanding transaction, its age in edges since acceptance, and the rr pointer.
    bit           m_out;
    int           m_age, m_rr, m_id;
    logic [W-1:0] m_a, m_b, m_data;
    logic [1:0]   m_op;
    logic         m_cout;

    task automatic model_reset();
        m_out = 0; m_age = 0; m_rr = 0; m_id = 0;
        m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_cout = 1'b0;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        if (m_out) return -1;
        for (int k = 0; k < NREQ; k++)
            if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        ta[i*W +: W] = a;
        tbv[i*W +: W] = b;
        top[i*2 +: 2] = op;
    endtask

    task automatic cycle(input logic [NREQ-1:0] v, input logic rdy, input bit rst_pulse);
        int w;
        @(negedge clk);
        bif.req_valid = v;
        bif.req_a     = ta;
        bif.req_b     = tbv;
        bif.req_op    = top;
        bif.rsp_ready = rdy;
        #1;
        w = pick(v);
        chk("req_ready", 32'(bif.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("busy", 32'(busy), 32'(m_out));
        chk("rsp_valid", 32'(bif.rsp_valid), 32'(m_out && m_age >= 1));
        if (m_out && m_age >= 1) begin
            chk("rsp_data", 32'(bif.rsp_data), 32'(m_data));
            chk("rsp_cout", 32'(bif.rsp_cout), 32'(m_cout));
        end
        chk("rsp_id", 32'(bif.rsp_id), 32'(m_id));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        if (rst_pulse) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            #1;
            model_reset();
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
            chk("rst_alu_a", 32'(alu_a), 32'd0);
            w = pick(v);
        end
        if (m_out) begin
            if (m_age == 0) begin
                {m_cout, m_data} = alu_ref(m_a, m_b, m_op);
                m_age = 1;
            end else if (rdy) m_out = 0;
        end else if (w >= 0) begin
            m_a   = ta[w*W +: W];
            m_b   = tbv[w*W +: W];
            m_op  = top[w*2 +: 2];
            m_id  = w;
            m_rr  = (w + 1) % NREQ;
            m_out = 1;
            m_age = 0;
        end
    endtask

    initial begin
        bif.req_valid = '0; bif.req_a = '0; bif.req_b = '0; bif.req_op = '0; bif.rsp_ready = 1'b0;
        ta = '0; tbv = '0; top = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(bif.req_ready), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_rsp_id", 32'(bif.rsp_id), 32'd0);
        rst_n = 1'b1;

        set_lane(0, 6'd5, 6'd10, 2'd0);
        cycle(4'b0001, 1'b1, 0);
        chk("single_grant", 32'(bif.req_ready), 32'h1);
        cycle(4'b0000, 1'b0, 0);
        cycle(4'b0000, 1'b0, 0);
        chk("single_valid", 32'(bif.rsp_valid), 32'd1);
        chk("single_data", 32'(bif.rsp_data), 32'd15);
        chk("single_cout", 32'(bif.rsp_cout), 32'd0);
        chk("single_id", 32'(bif.rsp_id), 32'd0);
        cycle(4'b0000, 1'b1, 0);

        set_lane(2, 6'd60, 6'd8, 2'd0);
        cycle(4'b0100, 1'b1, 0);
        cycle(4'b0000, 1'b1, 0);
        cycle(4'b0000, 1'b0, 0);
        chk("carry_data", 32'(bif.rsp_data), 32'd4);
        chk("carry_cout", 32'(bif.rsp_cout), 32'd1);
        chk("carry_id", 32'(bif.rsp_id), 32'd2);
        cycle(4'b0000, 1'b1, 0);

        cycle(4'b0001, 1'b1, 0);
        chk("prereset_grant", 32'(bif.req_ready), 32'h1);
        cycle(4'b0000, 1'b1, 1);
        cycle(4'b0000, 1'b1, 0);
        chk("postreset_valid", 32'(bif.rsp_valid), 32'd0);
        chk("postreset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < NREQ; i++) set_lane(i, W'(i * 7 + 3), W'(i + 1), 2'(i));
        for (int i = 0; i < 15; i++) begin
            cycle(4'b1111, 1'b1, 0);
            chk("fair_grant", 32'(bif.req_ready), (i % 3 == 0) ? (32'd1 << ((i / 3) % 4)) : 32'd0);
        end

        cycle(4'b1001, 1'b1, 0);
        chk("skip_first", 32'(bif.req_ready), 32'h8);
        cycle(4'b1001, 1'b1, 0);
        cycle(4'b1001, 1'b1, 0);
        cycle(4'b1001, 1'b1, 0);
        chk("skip_second", 32'(bif.req_ready), 32'h1);
        cycle(4'b0000, 1'b1, 0);
        cycle(4'b0000, 1'b1, 0);

        set_lane(1, 6'd7, 6'd9, 2'd1);
        cycle(4'b0010, 1'b1, 0);
        cycle(4'b0000, 1'b0, 0);
        repeat (5) begin
            cycle(4'b1111, 1'b0, 0);
            chk("bp_valid", 32'(bif.rsp_valid), 32'd1);
            chk("bp_data", 32'(bif.rsp_data), 32'd62);
            chk("bp_cout", 32'(bif.rsp_cout), 32'd1);
            chk("bp_ready", 32'(bif.req_ready), 32'd0);
        end
        cycle(4'b1111, 1'b1, 0);
        cycle(4'b1111, 1'b1, 0);
        chk("bp_next_grant", 32'(bif.req_ready), 32'h4);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) set_lane(i, W'($urandom()), W'($urandom()), 2'($urandom()));
            cycle(NREQ'($urandom()), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
